// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: cache geometry default, instruction width,
// fetch FSM encodings and a word-alignment helper.
package inst_fetch_pkg;

  localparam int INST_CACHE_INDEX_BITS = 4;
  localparam int INST_W                = 32;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_MISS = 1'b1
  } fetch_state_t;

  function automatic logic [INST_W-1:0] align_word(input logic [INST_W-1:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Decoder-facing and memory-facing signals of the fetch stage, bundled so the
// fetch unit (master) and its environment (slave) share one port list.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  // Decoder accepts inst_out when inst_ready_out is high and need_inst is low
  // in the same rdy cycle; memory: mem_req/mem_addr hold until a one-cycle
  // mem_ready pulse that carries mem_data.
  logic              need_inst;
  logic              clear_inst;
  logic [INST_W-1:0] if_addr;
  logic [INST_W-1:0] pc_out;
  logic [INST_W-1:0] inst_out;
  logic              inst_ready_out;
  logic              mem_req;
  logic [INST_W-1:0] mem_addr;
  logic              mem_ready;
  logic [INST_W-1:0] mem_data;

  modport master (
    input  need_inst, clear_inst, if_addr, mem_ready, mem_data,
    output pc_out, inst_out, inst_ready_out, mem_req, mem_addr
  );

  modport slave (
    output need_inst, clear_inst, if_addr, mem_ready, mem_data,
    input  pc_out, inst_out, inst_ready_out, mem_req, mem_addr
  );

endinterface

// File: rtl/inst_fetch_icache_array.sv
// Direct-mapped valid/tag/data storage: one combinational read port and one
// synchronous write port. Only reset clears valid bits.
module inst_fetch_icache_array
  import inst_fetch_pkg::*;
#(
  parameter int INDEX_BITS = INST_CACHE_INDEX_BITS,
  parameter int TAG_W      = 32 - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] i_rd_idx,
  output logic                  o_rd_valid,
  output logic [TAG_W-1:0]      o_rd_tag,
  output logic [INST_W-1:0]     o_rd_data,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]      i_wr_tag,
  input  logic [INST_W-1:0]     i_wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [INST_W-1:0] r_data [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int i = 0; i < LINES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_tag[i_wr_idx]   <= i_wr_tag;
      r_data[i_wr_idx]  <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, looks it up in a one-word-per-line
// direct-mapped cache, and fills misses from memory one word at a time.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          INDEX_BITS = INST_CACHE_INDEX_BITS,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  inst_fetch_if.master bus,
  output fetch_state_t o_dbg_state
);

  localparam int TAG_W = 32 - INDEX_BITS - 2;

  fetch_state_t      r_state;
  logic [INST_W-1:0] r_pc;
  logic [INST_W-1:0] r_mem_addr;
  logic [INST_W-1:0] r_redirect_pc;
  logic              r_mem_req;
  logic              r_pending;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_line_valid;
  logic [TAG_W-1:0]      w_line_tag;
  logic [INST_W-1:0]     w_line_data;
  logic                  w_hit;
  logic                  w_fill;
  logic [INST_W-1:0]     w_target;

  assign w_idx    = r_pc[INDEX_BITS+1:2];
  assign w_tag    = r_pc[31:INDEX_BITS+2];
  assign w_hit    = w_line_valid && (w_line_tag == w_tag);
  assign w_fill   = rdy && (r_state == FETCH_MISS) && bus.mem_ready;
  assign w_target = align_word(bus.if_addr);

  inst_fetch_icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_line_valid),
    .o_rd_tag   (w_line_tag),
    .o_rd_data  (w_line_data),
    .i_we       (w_fill),
    .i_wr_idx   (r_mem_addr[INDEX_BITS+1:2]),
    .i_wr_tag   (r_mem_addr[31:INDEX_BITS+2]),
    .i_wr_data  (bus.mem_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= FETCH_IDLE;
      r_pc          <= RESET_PC;
      r_mem_addr    <= '0;
      r_redirect_pc <= '0;
      r_mem_req     <= 1'b0;
      r_pending     <= 1'b0;
    end else if (rdy) begin
      case (r_state)
        FETCH_IDLE: begin
          if (bus.clear_inst) begin
            r_pc <= w_target;
          end else if (w_hit) begin
            if (!bus.need_inst) r_pc <= r_pc + 32'd4;
          end else begin
            r_state    <= FETCH_MISS;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
          end
        end
        FETCH_MISS: begin
          // The in-flight fill is never cancelled; a redirect is parked until it lands.
          if (bus.clear_inst) begin
            r_redirect_pc <= w_target;
            r_pending     <= 1'b1;
          end
          if (bus.mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= FETCH_IDLE;
            r_pending <= 1'b0;
            if (bus.clear_inst)  r_pc <= w_target;
            else if (r_pending)  r_pc <= r_redirect_pc;
          end
        end
        default: r_state <= FETCH_IDLE;
      endcase
    end
  end

  assign bus.pc_out         = r_pc;
  assign bus.inst_out       = w_line_data;
  assign bus.inst_ready_out = (r_state == FETCH_IDLE) && w_hit && !bus.clear_inst;
  assign bus.mem_req        = r_mem_req;
  assign bus.mem_addr       = r_mem_addr;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed and randomized checks of inst_fetch against an address-level model
// of the fetch stage (resident-word table plus outstanding-request queues).
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          LINES    = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  fetch_state_t dbg_state;

  inst_fetch_if bus();

  inst_fetch #(.INDEX_BITS(4), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // reference model: which word address each line holds, plus request queues
  logic [31:0] m_pc;
  logic [31:0] m_last_addr;
  logic [31:0] m_out_q[$];
  logic [31:0] m_redir_q[$];
  bit          m_line_v[LINES];
  logic [31:0] m_line_a[LINES];
  logic [31:0] m_line_d[LINES];

  // memory responder state
  bit          auto_mem;
  bit          rand_lat;
  bit          nop_mode;
  int          mem_cnt;
  int          mem_lat;
  logic [31:0] req_q[$];
  bit          prev_mr;
  bit          track_ready;
  int          ready_cnt;
  int          orphan_cnt;
  int          n;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (nop_mode) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd16);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int i;
    i = line_of(a);
    return m_line_v[i] && (m_line_a[i] == a);
  endfunction

  function automatic logic [31:0] q_at(input int i);
    if (i < req_q.size()) return req_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc        = RESET_PC;
    m_last_addr = 32'h0;
    m_out_q.delete();
    m_redir_q.delete();
    for (int i = 0; i < LINES; i++) begin
      m_line_v[i] = 1'b0;
      m_line_a[i] = 32'h0;
      m_line_d[i] = 32'h0;
    end
  endtask

  task automatic check_outputs();
    bit er;
    er = (m_out_q.size() == 0) && m_hit(m_pc) && !bus.clear_inst;
    chk("pc_out", bus.pc_out, m_pc);
    chk("inst_ready_out", 32'(bus.inst_ready_out), 32'(er));
    chk("inst_out", bus.inst_out, m_line_d[line_of(m_pc)]);
    chk("mem_req", 32'(bus.mem_req), 32'(m_out_q.size() != 0));
    chk("mem_addr", bus.mem_addr, m_last_addr);
    chk("dbg_state", 32'(dbg_state), 32'(m_out_q.size() != 0));
    if (track_ready && bus.inst_ready_out) begin
      ready_cnt++;
      if (!prev_mr) orphan_cnt++;
    end
  endtask

  task automatic model_update();
    logic [31:0] tgt;
    logic [31:0] a;
    int          i;
    prev_mr = rdy && bus.mem_ready;
    if (!rdy) return;
    tgt = bus.if_addr & ~32'h3;
    if (m_out_q.size() == 0) begin
      if (bus.clear_inst) m_pc = tgt;
      else if (m_hit(m_pc)) begin
        if (!bus.need_inst) m_pc = m_pc + 32'd4;
      end else begin
        m_out_q.push_back(m_pc);
        m_last_addr = m_pc;
      end
    end else begin
      if (bus.clear_inst) begin
        m_redir_q.delete();
        m_redir_q.push_back(tgt);
      end
      if (bus.mem_ready) begin
        a = m_out_q.pop_front();
        i = line_of(a);
        m_line_v[i] = 1'b1;
        m_line_a[i] = a;
        m_line_d[i] = bus.mem_data;
        if (m_redir_q.size() != 0) m_pc = m_redir_q.pop_front();
        m_redir_q.delete();
      end
    end
  endtask

  task automatic mem_drive();
    if (bus.mem_ready) begin
      bus.mem_ready = 1'b0;
      mem_cnt = 0;
    end else if (bus.mem_req) begin
      if (mem_cnt == 0) begin
        req_q.push_back(bus.mem_addr);
        if (rand_lat) mem_lat = $urandom_range(1, 4);
      end
      mem_cnt++;
      if (auto_mem && mem_cnt >= mem_lat) begin
        bus.mem_ready = 1'b1;
        bus.mem_data  = mem_word(bus.mem_addr);
      end
    end
  endtask

  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
    mem_drive();
  endtask

  task automatic redirect(input logic [31:0] a);
    bus.clear_inst = 1'b1;
    bus.if_addr    = a;
    tick();
    bus.clear_inst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1;
    bus.need_inst = 1'b1; bus.clear_inst = 1'b0; bus.if_addr = 32'h0;
    bus.mem_ready = 1'b0; bus.mem_data = 32'h0;
    auto_mem = 1'b1; rand_lat = 1'b0; nop_mode = 1'b1; mem_lat = 3; mem_cnt = 0;
    prev_mr = 1'b0; track_ready = 1'b0; ready_cnt = 0; orphan_cnt = 0;
    model_reset();

    #2;
    chk("rst_pc", bus.pc_out, RESET_PC);
    chk("rst_inst", bus.inst_out, 32'h0);
    chk("rst_ready", 32'(bus.inst_ready_out), 32'h0);
    chk("rst_req", 32'(bus.mem_req), 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // cold start: three misses served with a fixed three-cycle memory
    bus.need_inst = 1'b0;
    track_ready = 1'b1;
    n = 0;
    while (!(req_q.size() >= 3 && bus.pc_out == 32'hC) && n < 200) begin tick(); n++; end
    chk("cold_bound", 32'(n < 200), 32'h1);
    chk("cold_req0", q_at(0), 32'h0);
    chk("cold_req1", q_at(1), 32'h4);
    chk("cold_req2", q_at(2), 32'h8);
    chk("cold_ready_cnt", 32'(ready_cnt), 32'd3);
    chk("cold_ready_after_fill", 32'(orphan_cnt), 32'd0);
    track_ready = 1'b0;
    nop_mode = 1'b0;
    rand_lat = 1'b1;

    // prefill the rest of 0x00-0x3C, then stream hits
    n = 0;
    while (bus.pc_out != 32'h40 && n < 400) begin tick(); n++; end
    chk("prefill_bound", 32'(n < 400), 32'h1);
    redirect(32'h0);
    for (int k = 0; k < 16; k++) begin
      chk("hit_pc", bus.pc_out, 32'(k * 4));
      chk("hit_noreq", 32'(bus.mem_req), 32'h0);
      tick();
    end

    // decoder stall at 0x10
    redirect(32'h10);
    bus.need_inst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_pc", bus.pc_out, 32'h10);
      chk("stall_inst", bus.inst_out, mem_word(32'h10));
      chk("stall_ready", 32'(bus.inst_ready_out), 32'h1);
      tick();
    end
    bus.need_inst = 1'b0;
    tick();
    chk("stall_release_pc", bus.pc_out, 32'h14);

    // redirect on a hit: no +4, ready low in the clear cycle
    bus.clear_inst = 1'b1;
    bus.if_addr    = 32'h103;
    #1;
    chk("redir_ready_low", 32'(bus.inst_ready_out), 32'h0);
    tick();
    bus.clear_inst = 1'b0;
    chk("redir_pc", bus.pc_out, 32'h100);

    // redirect during a miss, memory driven by hand
    bus.need_inst = 1'b1;
    auto_mem = 1'b0;
    redirect(32'h40);
    tick();
    chk("miss_req", 32'(bus.mem_req), 32'h1);
    chk("miss_addr", bus.mem_addr, 32'h40);
    tick();
    redirect(32'h80);
    chk("miss_hold_addr0", bus.mem_addr, 32'h40);
    tick();
    chk("miss_hold_addr1", bus.mem_addr, 32'h40);
    chk("miss_hold_req", 32'(bus.mem_req), 32'h1);
    bus.mem_ready = 1'b1;
    bus.mem_data  = mem_word(32'h40);
    tick();
    chk("fill_pc_redirected", bus.pc_out, 32'h80);
    chk("fill_req_low", 32'(bus.mem_req), 32'h0);
    chk("fill_line_data", bus.inst_out, mem_word(32'h40));
    tick();
    chk("refetch_req", 32'(bus.mem_req), 32'h1);
    chk("refetch_addr", bus.mem_addr, 32'h80);
    bus.mem_ready = 1'b1;
    bus.mem_data  = mem_word(32'h80);
    tick();
    chk("refetch_ready", 32'(bus.inst_ready_out), 32'h1);
    chk("refetch_inst", bus.inst_out, mem_word(32'h80));

    // conflict on index 0 between 0x00 and 0x40
    redirect(32'h0);
    tick();
    chk("conf_req00", bus.mem_addr, 32'h0);
    bus.mem_ready = 1'b1; bus.mem_data = mem_word(32'h0);
    tick();
    chk("conf_hit00", 32'(bus.inst_ready_out), 32'h1);
    redirect(32'h40);
    chk("conf_miss40", 32'(bus.inst_ready_out), 32'h0);
    tick();
    chk("conf_req40", bus.mem_addr, 32'h40);
    bus.mem_ready = 1'b1; bus.mem_data = mem_word(32'h40);
    tick();
    chk("conf_hit40", 32'(bus.inst_ready_out), 32'h1);
    redirect(32'h0);
    chk("conf_evicted00", 32'(bus.inst_ready_out), 32'h0);
    tick();
    chk("conf_rereq00", 32'(bus.mem_req), 32'h1);

    // asynchronous reset while a request is outstanding
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(bus.mem_req), 32'h0);
    chk("arst_pc", bus.pc_out, RESET_PC);
    chk("arst_addr", bus.mem_addr, 32'h0);
    model_reset();
    bus.mem_ready = 1'b0;
    mem_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    auto_mem = 1'b1;
    #1;
    chk("arst_cache_cleared", 32'(bus.inst_ready_out), 32'h0);
    tick();
    chk("arst_refill_req", 32'(bus.mem_req), 32'h1);

    // PC wrap at the top of the address space
    n = 0;
    while (bus.mem_req && n < 20) begin tick(); n++; end
    redirect(32'hFFFF_FFFF);
    chk("wrap_pc", bus.pc_out, 32'hFFFF_FFFC);
    n = 0;
    while (!bus.inst_ready_out && n < 20) begin tick(); n++; end
    chk("wrap_bound", 32'(n < 20), 32'h1);
    bus.need_inst = 1'b0;
    tick();
    chk("wrap_to_zero", bus.pc_out, 32'h0);

    // randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      rdy            = ($urandom_range(0, 7) != 0);
      bus.need_inst  = ($urandom_range(0, 2) == 0);
      bus.clear_inst = ($urandom_range(0, 11) == 0);
      bus.if_addr    = $urandom_range(0, 255);
      tick();
    end
    rdy = 1'b1;
    bus.clear_inst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Front-end stage directly upstream of the decoder; owns the architectural fetch PC.
- Holds a direct-mapped instruction cache of one 32-bit word per line.
- Presents PC, instruction and a ready flag to the decoder, and advances the PC when the decoder accepts.
- Services misses through a single-word request/ready handshake to the memory controller, and redirects the PC on decoder clear requests.

Parameters:
- INDEX_BITS, 4, log2 of the number of cache lines (16 lines).
- RESET_PC, 32'h0, fetch address after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; low freezes all state
- need_inst  in  1  from decoder; low in a cycle with inst_ready_out high means the instruction is accepted
- clear_inst  in  1  from decoder; redirect request
- if_addr  in  32  redirect target, valid with clear_inst
- pc_out  out  32  current fetch PC
- inst_out  out  32  cached word at pc_out
- inst_ready_out  out  1  inst_out is valid for pc_out
- mem_req  out  1  word fetch request to memory controller
- mem_addr  out  32  word-aligned request address
- mem_ready  in  1  one-cycle pulse; mem_data valid
- mem_data  in  32  returned instruction word

Behaviour:
- Reset (rst==0, asynchronous):
  - pc <= RESET_PC; all valid bits <= 0; state <= IDLE; pending_redirect <= 0.
  - Outputs: mem_req 0, mem_addr 0, inst_ready_out 0, pc_out RESET_PC, inst_out 0.
- Address split:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[31:INDEX_BITS+2]
  - pc[1:0] is always 0; if_addr[1:0] is ignored and forced to 0.
- hit = valid[index] && tag_array[index]==tag, evaluated combinationally on the registered pc.
- inst_ready_out = (state==IDLE) && hit && !clear_inst.
- inst_out = data_array[index] (combinational).
- If rdy==0, no register changes; mem_req holds its value.
- States and transitions:
  - IDLE:
    - clear_inst=1 → pc <= {if_addr[31:2],2'b00}; stay IDLE. Redirect has priority over accept.
    - Else hit && need_inst==0 → pc <= pc+4 (32-bit wrap, 0xFFFFFFFC+4 = 0).
    - Else !hit → state <= MISS; mem_req <= 1; mem_addr <= pc.
  - MISS:
    - mem_req stays 1 and mem_addr stays stable until mem_ready.
    - On mem_ready:
      - data_array[idx(mem_addr)] <= mem_data; tag written; valid set.
      - mem_req <= 0; state <= IDLE.
      - If pending_redirect is set, pc <= redirect_pc and pending_redirect <= 0.
    - clear_inst during MISS: the outstanding request is not cancelled; record redirect_pc <= {if_addr[31:2],2'b00} and pending_redirect <= 1. A later clear overwrites the earlier one. Fill still completes into the cache.
    - clear_inst coinciding with mem_ready: the fresh if_addr wins over any pending value.
- Latency:
  - Hit: instruction visible in the same cycle the pc register updates, so back-to-back accepts give one instruction per cycle.
  - Miss: mem_req rises one cycle after the miss is detected; inst_ready_out rises the cycle after mem_ready.
- Accept rule: the PC advances only on inst_ready_out && !need_inst && rdy. While the decoder stalls (need_inst high), pc_out and inst_out hold.
- The cache is never invalidated except by reset (no self-modifying code support).

Decomposition:
- Shared const.v additions:
  - INST_CACHE_INDEX_BITS default.
  - Fetch state encodings FETCH_IDLE, FETCH_MISS.
  - Instruction word width.
- One sub-module, icache_array: valid/tag/data storage with one combinational read port and one synchronous write port. The top level holds the PC, FSM and memory handshake.

Test Plan:
- Cold start: reset, RESET_PC=0. Memory returns 0x00000013 three cycles after each mem_req. Expect mem_addr=0x0, then 0x4, 0x8, with one instruction per miss; inst_ready_out is high exactly one cycle after each mem_ready.
- Hit stream: prefill 0x0–0x3C, then hold need_inst=0. Expect pc_out to step 0x0,0x4,…,0x3C on consecutive cycles with no mem_req.
- Decoder stall: on a hit at pc 0x10, hold need_inst=1 for 5 cycles. Expect pc_out=0x10 and inst_out stable throughout; pc goes to 0x14 on the first cycle need_inst=0.
- Redirect on hit: clear_inst=1 and if_addr=0x103 in a cycle where need_inst=0. Expect pc_out=0x100 next cycle (no +4); inst_ready_out is low in the clear cycle.
- Redirect during miss:
  - Miss at 0x40, then clear_inst with if_addr=0x80 two cycles before mem_ready. Expect mem_addr to hold 0x40 until mem_ready.
  - Line 0x40 becomes valid, then pc=0x80, then a new miss request for 0x80.
- Conflict and reset:
  - 0x00 and 0x40 map to index 0: after filling 0x00, fetching 0x40 must miss and evict; refetching 0x00 misses again.
  - Assert rst=0 while mem_req=1: mem_req drops immediately (asynchronously) and all valid bits clear.
